// File: rtl/bram_stream_reader.sv
// bram_stream_reader: streams BRAM words out as DATA_OUT_WIDTH slices, LSB slice first, with ready/valid handshake.
// Optional abort input enabled by defining BRAM_STREAM_READER_ABORT_EN.
module bram_stream_reader #(
  parameter int ADDRESS_WIDTH   = 13,
  parameter int BRAM_DATA_WIDTH = 32,
  parameter int DATA_OUT_WIDTH  = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [ADDRESS_WIDTH-1:0]     base_addr_i,
  input  logic [ADDRESS_WIDTH:0]       num_words_i,
`ifdef BRAM_STREAM_READER_ABORT_EN
  input  logic                         abort_i,
`endif
  output logic                         busy_o,
  output logic                         done_o,
  output logic [DATA_OUT_WIDTH-1:0]    data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         last_o,
  output logic [ADDRESS_WIDTH-1:0]     bram_addr,
  output logic                         bram_en,
  output logic [BRAM_DATA_WIDTH/8-1:0] bram_we,
  input  logic [BRAM_DATA_WIDTH-1:0]   bram_data_out
);
  localparam int R  = BRAM_DATA_WIDTH / DATA_OUT_WIDTH;
  localparam int KW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {IDLE, READ, WAIT, SHIFT} state_t;

  state_t                     state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDRESS_WIDTH:0]     cnt_q, cnt_d;
  logic [KW-1:0]              k_q, k_d;
  logic [BRAM_DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic                       done_q, done_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      sreg_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      sreg_q  <= sreg_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    sreg_d  = sreg_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        if (num_words_i != '0) begin
          state_d = READ;
          addr_d  = base_addr_i;
          cnt_d   = num_words_i;
          k_d     = '0;
        end else begin
          done_d = 1'b1;
        end
      end
      READ: state_d = WAIT;
      WAIT: begin
        sreg_d  = bram_data_out;
        state_d = SHIFT;
      end
      SHIFT: if (ready_i) begin
        if (k_q == KW'(R - 1)) begin
          k_d     = '0;
          cnt_d   = cnt_q - (ADDRESS_WIDTH + 1)'(1);
          addr_d  = addr_q + ADDRESS_WIDTH'(1);
          state_d = (cnt_q == (ADDRESS_WIDTH + 1)'(1)) ? IDLE : READ;
          done_d  = (cnt_q == (ADDRESS_WIDTH + 1)'(1));
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef BRAM_STREAM_READER_ABORT_EN
    // Abort wins over everything, including a word landing from the BRAM this cycle.
    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      k_d     = '0;
      sreg_d  = '0;
      done_d  = 1'b1;
    end
`endif
  end

  assign busy_o    = state_q != IDLE;
  assign done_o    = done_q;
  assign valid_o   = state_q == SHIFT;
  assign data_o    = sreg_q[int'(k_q)*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
  assign last_o    = valid_o && k_q == KW'(R - 1) && cnt_q == (ADDRESS_WIDTH + 1)'(1);
  assign bram_addr = addr_q;
  assign bram_en   = state_q == READ;
  assign bram_we   = '0;
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: directed scoreboard bench for bram_stream_reader (R=4, behavioural BRAM).
module tb_bram_stream_reader;
  localparam int AW = 13, BW = 32, DW = 8;
  logic          clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0, ready_i = 1'b1;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW:0]   num_words_i = '0;
`ifdef BRAM_STREAM_READER_ABORT_EN
  logic          abort_i = 1'b0;
`endif
  logic          busy_o, done_o, valid_o, last_o, bram_en;
  logic [DW-1:0] data_o;
  logic [AW-1:0] bram_addr;
  logic [BW/8-1:0] bram_we;
  logic [BW-1:0] bram_data_out = '0;
  logic [BW-1:0] mem [0:(1<<AW)-1];

  bram_stream_reader #(.ADDRESS_WIDTH(AW), .BRAM_DATA_WIDTH(BW), .DATA_OUT_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .num_words_i(num_words_i),
`ifdef BRAM_STREAM_READER_ABORT_EN
    .abort_i(abort_i),
`endif
    .busy_o(busy_o), .done_o(done_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .last_o(last_o), .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
    .bram_data_out(bram_data_out));

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (bram_en) bram_data_out <= mem[bram_addr];

  int            n_cmp = 0, n_bad = 0;
  logic [8:0]    sb[$];
  logic [AW-1:0] rd_log[$];
  bit            rdy_mode = 0, chk_done = 1;
  logic          prev_last_acc = 0, prev_stall = 0, prev_lastv = 0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_words(input logic [AW-1:0] b, input int n);
    logic [BW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = mem[AW'(b + AW'(i))];
      for (int k = 0; k < BW/DW; k++) sb.push_back({(k == BW/DW-1) && (i == n-1), w[k*DW +: DW]});
    end
  endtask

  task automatic start_xfer(input logic [AW-1:0] b, input logic [AW:0] n);
    @(posedge clk_i); #1;
    start_i = 1'b1; base_addr_i = b; num_words_i = n;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400 && done_o !== 1'b1; i++) @(negedge clk_i);
    chk({tag, "_done"}, done_o, 1);
    chk({tag, "_idle"}, busy_o, 0);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  // Monitor: pops expected beats on every accepted handshake and polices stalls and done timing.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      prev_last_acc = 0;
      prev_stall = 0;
    end else begin
      if (chk_done) chk("done_timing", done_o, prev_last_acc);
      if (prev_stall) begin
        chk("stall_valid", valid_o, 1);
        chk("stall_data", data_o, prev_data);
        chk("stall_last", last_o, prev_lastv);
      end
      if (bram_en) rd_log.push_back(bram_addr);
      if (valid_o && ready_i) begin
        chk("beat_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          logic [8:0] e;
          e = sb.pop_front();
          chk("beat_data", data_o, e[7:0]);
          chk("beat_last", last_o, e[8]);
        end
      end
      prev_last_acc = valid_o && ready_i && last_o;
      prev_stall = valid_o && !ready_i;
      prev_data = data_o;
      prev_lastv = last_o;
    end
  end

  initial begin
    bit [3:0] pat;
    int c;
    pat = 4'b1001;
    c = 0;
    forever begin
      @(posedge clk_i); #1;
      if (rdy_mode) begin
        ready_i = pat[c % 4];
        c++;
      end else ready_i = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    mem[16] = 32'h44332211;
    mem[17] = 32'h88776655;
    mem[13'h1FFF] = 32'hDDCCBBAA;
    mem[0] = 32'h04030201;
    mem[32] = 32'hF0E0D0C0;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_en", bram_en, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_data", data_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_we", bram_we, 0);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;

    // Two words, ready held high: exact cycle timing.
    rd_log.delete();
    push_words(13'h010, 2);
    start_xfer(13'h010, 2);
    @(negedge clk_i);
    chk("t1_rd_en", bram_en, 1);
    chk("t1_rd_addr", bram_addr, 13'h010);
    chk("t1_busy", busy_o, 1);
    @(negedge clk_i);
    chk("t1_valid_c2", valid_o, 0);
    chk("t1_en_c2", bram_en, 0);
    @(negedge clk_i);
    chk("t1_valid_c3", valid_o, 1);
    chk("t1_data_c3", data_o, 8'h11);
    repeat (9) @(negedge clk_i);
    chk("t1_last_c12", last_o, 1);
    chk("t1_data_c12", data_o, 8'h88);
    @(negedge clk_i);
    chk("t1_done_c13", done_o, 1);
    wait_done("t1");
    chk("t1_nreads", rd_log.size(), 2);

    // Same transfer with ready toggling 1,0,0,1 and a start while busy that must be ignored.
    rd_log.delete();
    rdy_mode = 1;
    push_words(13'h010, 2);
    start_xfer(13'h010, 2);
    repeat (5) @(posedge clk_i);
    #1 start_i = 1'b1; base_addr_i = 13'h020; num_words_i = 1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    wait_done("t2");
    rdy_mode = 0;
    chk("t2_nreads", rd_log.size(), 2);
    chk("t2_rd0", rd_log[0], 13'h010);
    chk("t2_rd1", rd_log[1], 13'h011);

    // Address wrap.
    rd_log.delete();
    push_words(13'h1FFF, 2);
    start_xfer(13'h1FFF, 2);
    wait_done("t3");
    chk("t3_nreads", rd_log.size(), 2);
    chk("t3_rd0", rd_log[0], 13'h1FFF);
    chk("t3_rd1", rd_log[1], 13'h0000);

    // Zero-length start.
    @(posedge clk_i);
    #1 chk_done = 0;
    rd_log.delete();
    start_xfer(13'h010, 0);
    @(negedge clk_i);
    chk("t4_done", done_o, 1);
    chk("t4_busy", busy_o, 0);
    @(negedge clk_i);
    chk("t4_done_once", done_o, 0);
    repeat (3) begin
      @(negedge clk_i);
      chk("t4_valid", valid_o, 0);
    end
    chk("t4_nreads", rd_log.size(), 0);
    @(posedge clk_i);
    #1 chk_done = 1;

    // Reset mid-SHIFT at k=2, then a clean one-word transfer.
    push_words(13'h010, 2);
    start_xfer(13'h010, 2);
    for (int i = 0; i < 50 && !(valid_o === 1'b1 && data_o === 8'h33); i++) @(negedge clk_i);
    chk("t5_at_k2", data_o, 8'h33);
    #1 rst_i = 1'b0;
    #1;
    chk("t5_busy", busy_o, 0);
    chk("t5_valid", valid_o, 0);
    chk("t5_data", data_o, 0);
    chk("t5_last", last_o, 0);
    chk("t5_done", done_o, 0);
    chk("t5_en", bram_en, 0);
    chk("t5_addr", bram_addr, 0);
    sb.delete();
    rd_log.delete();
    #2 rst_i = 1'b1;
    repeat (4) @(negedge clk_i);
    chk("t5_no_reads", rd_log.size(), 0);
    push_words(13'h020, 1);
    start_xfer(13'h020, 1);
    wait_done("t5");

`ifdef BRAM_STREAM_READER_ABORT_EN
    // Abort during WAIT.
    @(posedge clk_i);
    #1 chk_done = 0;
    start_xfer(13'h010, 1);
    @(posedge clk_i);
    #1 abort_i = 1'b1;
    @(posedge clk_i);
    #1 abort_i = 1'b0;
    chk("t6_busy", busy_o, 0);
    chk("t6_done", done_o, 1);
    chk("t6_valid", valid_o, 0);
    repeat (3) begin
      @(negedge clk_i);
      chk("t6_valid_after", valid_o, 0);
      chk("t6_done_after", done_o, 0);
    end
    @(posedge clk_i);
    #1 chk_done = 1;
`endif

    repeat (2) @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 13: BRAM word-address width.
REQ-002 SHALL have parameter BRAM_DATA_WIDTH, default 32: BRAM read-port width.
REQ-003 SHALL have parameter DATA_OUT_WIDTH, default 8: output slice width. R = BRAM_DATA_WIDTH/DATA_OUT_WIDTH SHALL be an integer >= 1.
REQ-004 SHALL have port clk_i, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst_i, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start_i, input, 1: launch a transfer when idle.
REQ-007 SHALL have port base_addr_i, input, ADDRESS_WIDTH: first BRAM word address, sampled on accepted start.
REQ-008 SHALL have port num_words_i, input, ADDRESS_WIDTH+1: number of BRAM words, sampled on accepted start.
REQ-009 SHALL have port busy_o, output, 1: high whenever state is not IDLE.
REQ-010 SHALL have port done_o, output, 1: one-cycle pulse at transfer end.
REQ-011 SHALL have port data_o, output, DATA_OUT_WIDTH: current slice.
REQ-012 SHALL have port valid_o, output, 1: data_o valid.
REQ-013 SHALL have port ready_i, input, 1: downstream accepts the beat.
REQ-014 SHALL have port last_o, output, 1: final slice of the final word.
REQ-015 SHALL have port bram_addr, output, ADDRESS_WIDTH: BRAM address.
REQ-016 SHALL have port bram_en, output, 1: BRAM enable.
REQ-017 SHALL have port bram_we, output, BRAM_DATA_WIDTH/8: write-byte enables, tied to 0.
REQ-018 SHALL have port bram_data_out, input, BRAM_DATA_WIDTH: BRAM read data, one-cycle read latency.

Function
REQ-019 SHALL implement the FSM IDLE -> READ -> WAIT -> SHIFT -> (READ | IDLE).
REQ-020 IDLE: start_i=1 with num_words_i!=0 SHALL latch the address and count and go to READ. start_i=1 with num_words_i=0 SHALL pulse done_o the next cycle, issue no read and stay in IDLE.
REQ-021 READ (1 cycle): SHALL drive bram_en=1 and bram_addr=current address, then go to WAIT.
REQ-022 WAIT (1 cycle): bram_en=0. SHALL load bram_data_out into the shift register at the clock edge ending WAIT, then go to SHIFT.
REQ-023 SHIFT: valid_o=1. data_o SHALL be slice k (bits k*DATA_OUT_WIDTH upward), sent LSB slice first, k=0..R-1.
REQ-024 Beat accepted only when valid_o && ready_i. SHALL advance k only on acceptance. data_o, valid_o and last_o SHALL remain stable while ready_i=0.
REQ-025 On acceptance of slice R-1: SHALL decrement the remaining word count and increment the address. If words remain, go to READ; otherwise pulse done_o in the following cycle and go to IDLE.
REQ-026 First valid_o SHALL be asserted 3 cycles after the accepted start. With ready_i held high, each word SHALL occupy R+2 cycles.
REQ-027 Address SHALL wrap modulo 2^ADDRESS_WIDTH (max address + 1 -> 0).
REQ-028 last_o SHALL equal valid_o && k==R-1 && remaining words==1.
REQ-029 start_i while busy_o=1 SHALL be ignored. Latched parameters SHALL be unaffected.
REQ-030 R=1 SHALL be supported: one beat per word.

Reset
REQ-031 rst_i low SHALL, asynchronously and at any time including mid-transfer, force state=IDLE, bram_addr=0, bram_en=0, data_o=0, valid_o=0, last_o=0, done_o=0, busy_o=0, slice counter=0 and word count=0.
REQ-032 After rst_i deasserts, the block SHALL issue no BRAM read until a new accepted start.

Configuration
REQ-033 Macro BRAM_STREAM_READER_ABORT_EN: when defined, SHALL add input abort_i (1 bit). abort_i=1 in any non-IDLE state SHALL force IDLE at the next edge, drop valid_o, pulse done_o once and discard any in-flight BRAM data. When undefined, no abort_i port SHALL exist and transfers SHALL always complete.

Verification
REQ-034 R=4, base=0x010, num=2, BRAM[0x010]=0x44332211, BRAM[0x011]=0x88776655, ready=1 -> data_o 11,22,33,44,55,66,77,88; last_o on 88; done_o one cycle later; first valid 3 cycles after start.
REQ-035 Same stimulus, ready_i toggled 1,0,0,1 per cycle -> identical byte sequence, no duplicated or dropped beats, data_o stable while stalled.
REQ-036 base=0x1FFF, num=2 -> reads at 0x1FFF then 0x0000.
REQ-037 num=0 start -> done_o pulse one cycle later, bram_en never asserted, valid_o stays 0.
REQ-038 rst_i low during SHIFT at k=2 -> all outputs 0 immediately. A new start of 1 word then returns that word's 4 slices correctly.
REQ-039 With BRAM_STREAM_READER_ABORT_EN defined, abort_i pulse in WAIT -> valid_o never asserts, single done_o pulse, busy_o=0 next cycle.
